// File: rtl/washer_pkg.sv
// Shared washer definitions: arbiter states, wash modes, fill-time budgets.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package washer_pkg;

    // Inlet-valve arbiter states
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_SETTLE = 2'd2
    } arb_state_e;

    // Wash mode encodings as seen on the controller bus
    typedef enum logic [1:0] {
        MODE_LIGHT  = 2'b00,
        MODE_NORMAL = 2'b01,
        MODE_HEAVY  = 2'b10
    } washer_mode_e;

    // Fill-time budgets in arbiter clock cycles; the arbiter timeout is sized
    // from the mode it must accommodate (NORMAL by default).
    localparam int FILL_CYCLES_LIGHT  = 10;
    localparam int FILL_CYCLES_NORMAL = 15;
    localparam int FILL_CYCLES_HEAVY  = 24;

    // Fill budget for a given wash mode
    function automatic int fill_cycles(input washer_mode_e mode);
        case (mode)
            MODE_LIGHT:  fill_cycles = FILL_CYCLES_LIGHT;
            MODE_HEAVY:  fill_cycles = FILL_CYCLES_HEAVY;
            default:     fill_cycles = FILL_CYCLES_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/fill_valve_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; found_o low when no request is set.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic             found_o,
    output logic [N_REQ-1:0] pick_o,
    output logic [IDW-1:0]   pick_id_o
);

    logic [IDW:0] sum;

    // Scan from ptr_i upward, wrapping modulo N_REQ; first hit wins
    always_comb begin
        found_o   = 1'b0;
        pick_id_o = '0;
        sum       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr_i} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(N_REQ)) begin
                sum = sum - (IDW+1)'(N_REQ);
            end
            if (!found_o && req_i[sum[IDW-1:0]]) begin
                found_o   = 1'b1;
                pick_id_o = sum[IDW-1:0];
            end
        end
    end

    assign pick_o = found_o ? (N_REQ'(1) << pick_id_o) : '0;

endmodule

// File: rtl/fill_valve_arbiter.sv
// Round-robin owner of the shared inlet valve with fill timeout and settle gap.
// Latency: grant registered one edge after req is seen in IDLE; >= GAP_CYCLES+1 closed cycles between owners.
// Backpressure: level requests simply wait while the valve is owned or settling; none are dropped.
module fill_valve_arbiter
    import washer_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int MAX_FILL_CYCLES = FILL_CYCLES_NORMAL,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         done_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic                     valve_open_o,
    output logic [N_REQ-1:0]         timeout_o,
    output logic                     busy_o
);

    localparam int IDW = $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE   = ARB_IDLE;
    localparam logic [1:0] ST_GRANT  = ARB_GRANT;
    localparam logic [1:0] ST_SETTLE = ARB_SETTLE;

    localparam logic [7:0]     FILL_LAST = 8'(MAX_FILL_CYCLES - 1);
    localparam logic [3:0]     GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [IDW-1:0] ID_LAST   = IDW'(N_REQ - 1);

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0] timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             valve_q, valve_d;
    logic [7:0]       fill_cnt_q, fill_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;

    logic             found;
    logic [N_REQ-1:0] pick;
    logic [IDW-1:0]   pick_id;
    logic             rel_done, rel_drop, expired;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .found_o   (found),
        .pick_o    (pick),
        .pick_id_o (pick_id)
    );

    // Only the owner's done/req matter; foreign done pulses fall out here
    assign rel_done = done_i[grant_id_q];
    assign rel_drop = !req_i[grant_id_q];
    assign expired  = (fill_cnt_q == FILL_LAST);

    // Next-state: grant selection, hold/timeout release, settle countdown
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        fill_cnt_d = fill_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        timeout_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d    = pick;
                    grant_id_d = pick_id;
                    fill_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel_done || rel_drop || expired) begin
                    grant_d   = '0;
                    ptr_d     = (grant_id_q == ID_LAST) ? '0 : grant_id_q + IDW'(1);
                    gap_cnt_d = '0;
                    state_d   = ST_SETTLE;
                    // A normal release in the expiry cycle wins over the timeout
                    if (expired && !rel_done && !rel_drop) begin
                        timeout_d = grant_q;
                    end
                end else begin
                    fill_cnt_d = fill_cnt_q + 8'd1;
                end
            end
            ST_SETTLE: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d  = (state_d != ST_IDLE);
        valve_d = |grant_d;
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            timeout_q  <= '0;
            busy_q     <= 1'b0;
            valve_q    <= 1'b0;
            fill_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            valve_q    <= valve_d;
            fill_cnt_q <= fill_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign grant_o      = grant_q;
    assign grant_id_o   = grant_id_q;
    assign valve_open_o = valve_q;
    assign timeout_o    = timeout_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_fill_valve_arbiter.sv
// Scoreboard bench for fill_valve_arbiter (N_REQ=4, MAX_FILL_CYCLES=15, GAP_CYCLES=2).
// Each grant episode is pushed as an expected record; the monitor pops on every grant rise.
// Directed scenarios: round robin, single requester, timeout, expiry tie, foreign done, reset.
module tb_fill_valve_arbiter;

    localparam int GAP = 2;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant_o;
    logic [1:0] grant_id_o;
    logic       valve_open_o;
    logic [3:0] timeout_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] id;
        int         hold;   // -1: episode cut by reset, drop not checked
        logic [3:0] tmo;
        int         gap;    // -1: closed-cycle count before this grant not checked
    } exp_t;

    exp_t sb[$];

    fill_valve_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req),
        .done_i       (done),
        .grant_o      (grant_o),
        .grant_id_o   (grant_id_o),
        .valve_open_o (valve_open_o),
        .timeout_o    (timeout_o),
        .busy_o       (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] id, input int hold,
                        input logic [3:0] tmo, input int gap);
        exp_t e;
        e.grant = g; e.id = id; e.hold = hold; e.tmo = tmo; e.gap = gap;
        sb.push_back(e);
    endtask

    // Monitor: pops one record per grant episode and checks rise, hold and drop
    exp_t cur;
    bit   in_g   = 1'b0;
    int   hold_c = 0;
    int   closed = -1;

    always @(negedge clk) begin
        if (reset) begin
            in_g   = 1'b0;
            closed = -1;
        end else if (!in_g && grant_o != 4'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got %b, required no grant", grant_o);
                cur.hold = -1; cur.tmo = 4'b0;
            end else begin
                cur = sb.pop_front();
                chk("grant", grant_o, cur.grant);
                chk("grant_id", grant_id_o, cur.id);
                chk("valve_on_grant", valve_open_o, 1);
                chk("busy_on_grant", busy_o, 1);
                if (cur.gap >= 0) chk("closed_gap", closed, cur.gap);
            end
            in_g   = 1'b1;
            hold_c = 1;
        end else if (in_g && grant_o != 4'b0) begin
            hold_c++;
            chk("timeout_during_hold", timeout_o, 0);
        end else if (in_g) begin
            in_g = 1'b0;
            if (cur.hold >= 0) chk("hold_len", hold_c, cur.hold);
            chk("timeout_at_drop", timeout_o, cur.tmo);
            chk("valve_at_drop", valve_open_o, 0);
            chk("busy_at_drop", busy_o, 1);
            closed = 1;
        end else if (closed > 0) begin
            closed++;
            if (closed == 2) chk("timeout_one_cycle", timeout_o, 0);
            if (closed == GAP + 1) chk("busy_idle", busy_o, 0);
        end
    end

    task automatic wait_grant();
        int n = 0;
        @(negedge clk);
        while (grant_o == 4'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (grant_o == 4'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_grant: grant %b, required nonzero within 60 cycles", grant_o);
        end
    endtask

    task automatic wait_drop();
        int n = 0;
        while (grant_o != 4'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (grant_o != 4'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_drop: grant %b, required zero within 60 cycles", grant_o);
        end
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_grant_id"}, grant_id_o, 0);
        chk({tag, "_valve"}, valve_open_o, 0);
        chk({tag, "_timeout"}, timeout_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0;
        done  = 4'b0;
        repeat (3) @(negedge clk);
        reset_vals("rst");
        #1 reset = 1'b0;

        // Round robin from ptr=0, done after 3 grant cycles each
        @(negedge clk);
        push(4'b0001, 2'd0, 3, 4'b0, -1);
        push(4'b0010, 2'd1, 3, 4'b0, 3);
        push(4'b0100, 2'd2, 3, 4'b0, 3);
        push(4'b1000, 2'd3, 3, 4'b0, 3);
        push(4'b0001, 2'd0, 3, 4'b0, 3);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant();
            repeat (2) @(negedge clk);
            done = 4'b0001 << (k % 4);
            @(negedge clk);
            done = 4'b0;
            if (k == 4) req = 4'b0;
        end
        repeat (8) @(negedge clk);

        // Single requester, one-cycle latency, done in 6th grant cycle (ptr=1)
        push(4'b0100, 2'd2, 6, 4'b0, -1);
        req = 4'b0100;
        @(negedge clk);
        chk("single_latency", grant_o, 4'b0100);
        repeat (5) @(negedge clk);
        done = 4'b0100;
        @(negedge clk);
        done = 4'b0;
        req  = 4'b0;
        repeat (8) @(negedge clk);

        // Timeout: ptr=3 wraps to 0, full 15-cycle hold, regrant after gap
        push(4'b0001, 2'd0, 15, 4'b0001, -1);
        push(4'b0001, 2'd0, 2, 4'b0, 3);
        req = 4'b0001;
        wait_grant();
        wait_drop();
        wait_grant();
        @(negedge clk);
        req = 4'b0;
        repeat (8) @(negedge clk);

        // done in the expiry cycle: normal release, no timeout
        push(4'b0010, 2'd1, 15, 4'b0, -1);
        req = 4'b0010;
        wait_grant();
        repeat (14) @(negedge clk);
        done = 4'b0010;
        @(negedge clk);
        done = 4'b0;
        req  = 4'b0;
        repeat (8) @(negedge clk);

        // Owner 3 with foreign done[0] pulses, releases on req drop, wraps to 0
        push(4'b1000, 2'd3, 4, 4'b0, -1);
        push(4'b0001, 2'd0, 1, 4'b0, 3);
        req = 4'b1001;
        wait_grant();
        @(negedge clk);
        done = 4'b0001;
        @(negedge clk);
        done = 4'b0;
        @(negedge clk);
        req  = 4'b0001;
        done = 4'b0001;
        @(negedge clk);
        done = 4'b0;
        wait_grant();
        done = 4'b0001;
        @(negedge clk);
        done = 4'b0;
        req  = 4'b0;
        repeat (8) @(negedge clk);

        // Move ptr to 2 so the post-reset pick shows ptr was cleared
        push(4'b0010, 2'd1, 2, 4'b0, -1);
        req = 4'b0010;
        wait_grant();
        @(negedge clk);
        req = 4'b0;
        repeat (8) @(negedge clk);

        // Reset in 5th grant cycle of owner 3, then 4'b1010 must go to 1
        push(4'b1000, 2'd3, -1, 4'b0, -1);
        req = 4'b1000;
        wait_grant();
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1 reset_vals("async_rst");
        @(negedge clk);
        push(4'b0010, 2'd1, 2, 4'b0, -1);
        #1;
        req   = 4'b1010;
        reset = 1'b0;
        wait_grant();
        @(negedge clk);
        req = 4'b0;
        repeat (10) @(negedge clk);

        chk("scoreboard_empty", sb.size(), 0);
        chk("final_busy", busy_o, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
